fixed_point_alu_pipe: RTL and testbench
=======================================

Name: fixed_point_alu_pipe

Overview:
Parametrised, 2-stage pipelined successor to the combinational fixed-point ALU used by the ray-march datapath.
- Adds configurable width and fraction bits, optional saturation with an overflow flag, and ABS on the previously reserved opcode.
- Adds a valid/ready handshake with backpressure and a sideband tag carried alongside each result.
- Sits between the ray-step sequencer and the distance-estimator pipeline, so an operation can issue every cycle.

Parameters:
- WIDTH, 32, total signed fixed-point width.
- FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC); must satisfy 1 <= FRAC < WIDTH-1.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.
- TAG_W, 4, width of the sideband tag carried with each operation.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, synchronous, active-high.
- valid_in  input  1  operation presented.
- ready_out  output  1  block accepts the operation this cycle.
- d0_in  input  WIDTH  signed operand 0.
- d1_in  input  WIDTH  signed operand 1 (left-hand side: d1 op d0).
- sel_in  input  3  opcode.
- tag_in  input  TAG_W  sideband tag.
- valid_out  output  1  result valid.
- ready_in  input  1  downstream accepts the result.
- res_out  output  WIDTH  signed result.
- gt_out  output  1  d1 > d0.
- eq_out  output  1  d1 == d0.
- lt_out  output  1  d1 < d0.
- ovf_out  output  1  result overflowed (clamped or wrapped).
- err_out  output  1  illegal opcode.
- tag_out  output  TAG_W  tag of this result.

Behaviour:
- Opcodes:
  - 000 ADD d1+d0.
  - 001 MUL (d1*d0)>>>FRAC; full 2*WIDTH product, arithmetic shift, truncation toward -inf.
  - 010 ABS |d1|.
  - 011 MAX.
  - 100 SUB d1-d0.
  - 101 SIGN: +1.0 (1<<FRAC) if d1>0, 0 if d1==0, -1.0 if d1<0.
  - 110 MIN.
  - 111 illegal: res=0, err_out=1, ovf_out=0.
- Overflow:
  - ADD/SUB: computed at WIDTH+1 bits; overflow when the top two bits differ.
  - MUL: overflow when shifted product bits [2*WIDTH-1 : WIDTH-1] are not all equal.
  - ABS: overflow on the most-negative input; result +MAX when saturating, unchanged when wrapping.
  - SATURATE=1 clamps to 0x7F..F / 0x80..0 and sets ovf_out.
  - SATURATE=0 keeps the low WIDTH bits and still sets ovf_out.
- Flags: signed comparison of d1 vs d0 for every opcode, including 111; exactly one of gt/eq/lt is 1.
- Pipeline:
  - S1 registers the operands, opcode, tag and the raw sum, difference and product.
  - S2 registers the shift, clamp, select and flags.
  - Latency is 2 cycles from acceptance to valid_out when there is no stall.
- Handshake:
  - Transfer in when valid_in & ready_out; transfer out when valid_out & ready_in.
  - Pipeline advance: adv = ~valid_out | ready_in; ready_out = adv (combinational).
  - When adv=0 both stages hold all registers; outputs stay stable while valid_out=1 & ready_in=0.
  - Bubbles propagate; a stage with valid=0 does not hold a slot.
  - Sustained throughput is 1 op/cycle with ready_in tied high.
- Simultaneous accept and drain in the same cycle is legal and is the steady state.
- Reset:
  - rst_in=1 clears both stage valid bits; valid_out=0, res_out=0, all flags 0, tag_out=0 on the next edge.
  - In-flight operations are discarded, not completed.
  - ready_out=1 while the pipeline is empty, including during reset.
- Operand or opcode values are ignored when valid_in=0.

Decomposition:
- Shared package/include fixed_point_arith.vh gains:
  - opcode localparams OP_ADD..OP_MIN, OP_ABS, OP_ILLEGAL;
  - width-parametrised MAX/MIN constants;
  - the fp_* function family, widened to take WIDTH/FRAC.
- WIDTH default stays in types.vh.
- One sub-module fp_sat_round (combinational): takes the wide raw result, opcode and SATURATE; returns res, ovf.
- Used in S2 so the clamp logic is verifiable in isolation.

Test Plan:
- Q16.16, ready_in=1: ADD d1=0x00018000 d0=0x00024000 -> res 0x0003C000 two cycles later, lt=1, ovf=0.
- MUL d1=0x00018000 (1.5), d0=0xFFFE0000 (-2.0) -> 0xFFFD0000; SIGN d1=0xFFFF0000 -> 0xFFFF0000; ABS d1=0x80000000 -> 0x7FFFFFFF, ovf=1.
- ADD 0x7FFF0000+0x00020000: SATURATE=1 -> 0x7FFFFFFF ovf=1; SATURATE=0 -> 0x80010000 ovf=1.
- Issue 4 back-to-back ops tagged 0..3 with ready_in=0 from cycle 3 to cycle 6:
  - ready_out drops while the pipeline is full;
  - result 0 is held stable;
  - after release, results appear in tag order 0,1,2,3 with none lost or duplicated.
- sel=111 with d1=d0=5 -> res 0, err=1, eq=1; then sel=011 MAX(-1.0, 2.0) -> 0x00020000, err=0.
- Assert rst_in for 1 cycle with 2 ops in flight -> next cycle valid_out=0, ready_out=1; a new op issued after reset returns 2 cycles later with the correct result.

Source files
------------

// File: rtl/fixed_point_alu_pipe_pkg.sv
// Shared definitions for the pipelined fixed-point ALU.
//   op_e    : 3-bit opcode encoding (d1 is the left-hand operand: d1 op d0)
//   cmp_t   : signed comparison flags of d1 versus d0
//   is_illegal() : true for the one opcode that produces an error result
package fixed_point_alu_pipe_pkg;

   typedef enum logic [2:0] {
      OP_ADD     = 3'b000,
      OP_MUL     = 3'b001,
      OP_ABS     = 3'b010,
      OP_MAX     = 3'b011,
      OP_SUB     = 3'b100,
      OP_SIGN    = 3'b101,
      OP_MIN     = 3'b110,
      OP_ILLEGAL = 3'b111
   } op_e;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_t;

   function automatic logic is_illegal(input op_e op);
      return (op == OP_ILLEGAL);
   endfunction

endpackage

// File: rtl/fixed_point_alu_pipe_sat_round.sv
// Combinational clamp / wrap stage of the fixed-point ALU.
//   raw  : 2*WIDTH-bit signed raw result (already shifted for MUL)
//   sel  : opcode of the operation; the illegal opcode forces res=0, ovf=0
//   res  : WIDTH-bit result, clamped (SATURATE=1) or low bits kept (SATURATE=0)
//   ovf  : raw did not fit in WIDTH signed bits
module fixed_point_alu_pipe_sat_round
   import fixed_point_alu_pipe_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int SATURATE = 1
) (
   input  logic [2*WIDTH-1:0] raw,
   input  op_e                sel,
   output logic [WIDTH-1:0]   res,
   output logic               ovf
);

   localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   // The value fits in WIDTH signed bits exactly when every bit from the
   // WIDTH-1 sign position upward is a copy of the same sign.
   logic fits;
   assign fits = (&raw[2*WIDTH-1:WIDTH-1]) | ~(|raw[2*WIDTH-1:WIDTH-1]);

   always_comb begin
      res = raw[WIDTH-1:0];
      ovf = 1'b0;
      if (is_illegal(sel)) begin
         res = '0;
      end else if (!fits) begin
         ovf = 1'b1;
         if (SATURATE != 0) begin
            res = raw[2*WIDTH-1] ? MIN_VAL : MAX_VAL;
         end
      end
   end

endmodule

// File: rtl/fixed_point_alu_pipe.sv
// Two-stage pipelined signed fixed-point ALU, Q(WIDTH-FRAC).FRAC.
//   clk_in, rst_in      : clock, synchronous active-high reset
//   valid_in, ready_out : operation input handshake
//   d1_in, d0_in, sel_in: operands and opcode (result = d1 op d0)
//   tag_in / tag_out    : sideband tag travelling with each operation
//   valid_out, ready_in : result output handshake
//   res_out             : result; gt/eq/lt_out signed compare of d1 vs d0
//   ovf_out, err_out    : result overflowed / illegal opcode
// FRAC must satisfy 1 <= FRAC < WIDTH-1.
//
// Handshake: a word moves in on a rising edge where valid_in & ready_out, and
// out on a rising edge where valid_out & ready_in. Both stages advance together
// when adv = ~valid_out | ready_in, and ready_out is adv combinationally. With
// adv low every register holds, so outputs are stable while stalled.
module fixed_point_alu_pipe
   import fixed_point_alu_pipe_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 16,
   parameter int SATURATE = 1,
   parameter int TAG_W    = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] d0_in,
   input  logic [WIDTH-1:0] d1_in,
   input  logic [2:0]       sel_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] res_out,
   output logic             gt_out,
   output logic             eq_out,
   output logic             lt_out,
   output logic             ovf_out,
   output logic             err_out,
   output logic [TAG_W-1:0] tag_out
);

   localparam logic [2*WIDTH-1:0] ONE_X   = {{(2*WIDTH-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [2*WIDTH-1:0] M_ONE_X = ~ONE_X + 1'b1;

   logic adv;

   // stage 1 registers
   logic                      v1;
   logic [WIDTH-1:0]          d0_r, d1_r;
   op_e                       sel_r;
   logic [TAG_W-1:0]          tag_r;
   logic [WIDTH:0]            sum_r, diff_r;
   logic signed [2*WIDTH-1:0] prod_r;

   // stage 2 registers
   logic             v2;
   logic [WIDTH-1:0] res_r;
   cmp_t             cmp_r;
   logic             ovf_r, err_r;
   logic [TAG_W-1:0] tag2_r;

   assign adv       = ~v2 | ready_in;
   assign ready_out = adv;

   // ---------------- stage 1: raw arithmetic ----------------
   logic signed [2*WIDTH-1:0] d1x_in, d0x_in, prod_next;
   logic [WIDTH:0]            sum_next, diff_next;

   assign d1x_in    = {{WIDTH{d1_in[WIDTH-1]}}, d1_in};
   assign d0x_in    = {{WIDTH{d0_in[WIDTH-1]}}, d0_in};
   assign prod_next = d1x_in * d0x_in;
   assign sum_next  = {d1_in[WIDTH-1], d1_in} + {d0_in[WIDTH-1], d0_in};
   assign diff_next = {d1_in[WIDTH-1], d1_in} - {d0_in[WIDTH-1], d0_in};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v1     <= 1'b0;
         d0_r   <= '0;
         d1_r   <= '0;
         sel_r  <= OP_ADD;
         tag_r  <= '0;
         sum_r  <= '0;
         diff_r <= '0;
         prod_r <= '0;
      end else if (adv) begin
         v1 <= valid_in;
         if (valid_in) begin
            d0_r   <= d0_in;
            d1_r   <= d1_in;
            sel_r  <= op_e'(sel_in);
            tag_r  <= tag_in;
            sum_r  <= sum_next;
            diff_r <= diff_next;
            prod_r <= prod_next;
         end
      end
   end

   // ---------------- stage 2: shift, select, clamp, flags ----------------
   logic signed [2*WIDTH-1:0] shifted;
   logic [2*WIDTH-1:0]        d1x, d0x, raw;
   cmp_t                      cmp_next;
   logic [WIDTH-1:0]          res_next;
   logic                      ovf_next;

   // Arithmetic shift of the full product truncates toward -inf.
   assign shifted = prod_r >>> FRAC;
   assign d1x     = {{WIDTH{d1_r[WIDTH-1]}}, d1_r};
   assign d0x     = {{WIDTH{d0_r[WIDTH-1]}}, d0_r};

   always_comb begin
      cmp_next.gt = $signed(d1_r) >  $signed(d0_r);
      cmp_next.eq = (d1_r == d0_r);
      cmp_next.lt = $signed(d1_r) <  $signed(d0_r);
   end

   // Every opcode is expressed as a sign-extended 2*WIDTH value so a single
   // range check in the clamp stage covers all overflow cases, including
   // ABS of the most-negative input.
   always_comb begin
      raw = '0;
      case (sel_r)
         OP_ADD:  raw = {{(WIDTH-1){sum_r[WIDTH]}}, sum_r};
         OP_SUB:  raw = {{(WIDTH-1){diff_r[WIDTH]}}, diff_r};
         OP_MUL:  raw = shifted;
         OP_ABS:  raw = d1_r[WIDTH-1] ? (~d1x + 1'b1) : d1x;
         OP_MAX:  raw = cmp_next.gt ? d1x : d0x;
         OP_MIN:  raw = cmp_next.lt ? d1x : d0x;
         OP_SIGN: begin
            if (cmp_sign_pos(d1_r))   raw = ONE_X;
            else if (d1_r == '0)      raw = '0;
            else                      raw = M_ONE_X;
         end
         default: raw = '0;
      endcase
   end

   function automatic logic cmp_sign_pos(input logic [WIDTH-1:0] v);
      return ~v[WIDTH-1] & (|v);
   endfunction

   fixed_point_alu_pipe_sat_round #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_sat_round (
      .raw (raw),
      .sel (sel_r),
      .res (res_next),
      .ovf (ovf_next)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v2     <= 1'b0;
         res_r  <= '0;
         cmp_r  <= '0;
         ovf_r  <= 1'b0;
         err_r  <= 1'b0;
         tag2_r <= '0;
      end else if (adv) begin
         v2 <= v1;
         if (v1) begin
            res_r  <= res_next;
            cmp_r  <= cmp_next;
            ovf_r  <= ovf_next;
            err_r  <= is_illegal(sel_r);
            tag2_r <= tag_r;
         end
      end
   end

   assign valid_out = v2;
   assign res_out   = res_r;
   assign gt_out    = cmp_r.gt;
   assign eq_out    = cmp_r.eq;
   assign lt_out    = cmp_r.lt;
   assign ovf_out   = ovf_r;
   assign err_out   = err_r;
   assign tag_out   = tag2_r;

endmodule

// File: tb/tb_fixed_point_alu_pipe.sv
// Self-checking bench for fixed_point_alu_pipe. Two instances share one
// stimulus stream: one clamping, one wrapping. A scoreboard queue per instance
// holds the reference-model results; a monitor compares at each negedge.
module tb_fixed_point_alu_pipe;

   localparam int W  = 32;
   localparam int FR = 16;
   localparam int TW = 4;

   localparam logic [2:0] ADD = 3'd0, MUL = 3'd1, ABS = 3'd2, MAX = 3'd3,
                          SUB = 3'd4, SGN = 3'd5, MIN = 3'd6, ILL = 3'd7;

   typedef struct packed {
      logic [W-1:0]  res;
      logic          ovf;
      logic          err;
      logic          gt;
      logic          eq;
      logic          lt;
      logic [TW-1:0] tag;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_in;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic          valid_in, ready_in;
   logic [W-1:0]  d0_in, d1_in;
   logic [2:0]    sel_in;
   logic [TW-1:0] tag_in;

   logic          ready_s, valid_s, gt_s, eq_s, lt_s, ovf_s, err_s;
   logic [W-1:0]  res_s;
   logic [TW-1:0] tag_s;
   logic          ready_w, valid_w, gt_w, eq_w, lt_w, ovf_w, err_w;
   logic [W-1:0]  res_w;
   logic [TW-1:0] tag_w;

   fixed_point_alu_pipe #(.WIDTH(W), .FRAC(FR), .SATURATE(1), .TAG_W(TW)) dut_sat (
      .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_s),
      .d0_in(d0_in), .d1_in(d1_in), .sel_in(sel_in), .tag_in(tag_in),
      .valid_out(valid_s), .ready_in(ready_in), .res_out(res_s),
      .gt_out(gt_s), .eq_out(eq_s), .lt_out(lt_s), .ovf_out(ovf_s),
      .err_out(err_s), .tag_out(tag_s)
   );

   fixed_point_alu_pipe #(.WIDTH(W), .FRAC(FR), .SATURATE(0), .TAG_W(TW)) dut_wrap (
      .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_w),
      .d0_in(d0_in), .d1_in(d1_in), .sel_in(sel_in), .tag_in(tag_in),
      .valid_out(valid_w), .ready_in(ready_in), .res_out(res_w),
      .gt_out(gt_w), .eq_out(eq_w), .lt_out(lt_w), .ovf_out(ovf_w),
      .err_out(err_w), .tag_out(tag_w)
   );

   // ---------------- scoreboard state ----------------
   exp_t exp_s_q[$];
   exp_t exp_w_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: plain integer arithmetic on the real values.
   function automatic exp_t model(input logic [2:0] sel, input logic [W-1:0] d1,
                                  input logic [W-1:0] d0, input logic [TW-1:0] tag,
                                  input bit sat);
      longint a, b, r, maxv, minv, one, m;
      exp_t   e;
      a    = longint'($signed(d1));
      b    = longint'($signed(d0));
      maxv = (longint'(1) <<< (W-1)) - 1;
      minv = -(longint'(1) <<< (W-1));
      one  = longint'(1) <<< FR;
      e.gt = (a > b);
      e.eq = (a == b);
      e.lt = (a < b);
      e.tag = tag;
      e.err = 1'b0;
      e.ovf = 1'b0;
      case (sel)
         ADD:     r = a + b;
         SUB:     r = a - b;
         MUL:     r = (a * b) >>> FR;
         ABS:     r = (a < 0) ? -a : a;
         MAX:     r = (a > b) ? a : b;
         MIN:     r = (a < b) ? a : b;
         SGN:     r = (a > 0) ? one : ((a == 0) ? 0 : -one);
         default: begin r = 0; e.err = 1'b1; end
      endcase
      m = r;
      if (r > maxv || r < minv) begin
         e.ovf = 1'b1;
         if (sat) m = (r > 0) ? maxv : minv;
      end
      e.res = m[W-1:0];
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_out(input string who, input exp_t e, input exp_t a);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s_result: got res=%h ovf=%b err=%b gt/eq/lt=%b%b%b tag=%0d, expected res=%h ovf=%b err=%b gt/eq/lt=%b%b%b tag=%0d (t=%0t)",
                  who, a.res, a.ovf, a.err, a.gt, a.eq, a.lt, a.tag,
                  e.res, e.ovf, e.err, e.gt, e.eq, e.lt, e.tag, $time);
      end
   endtask

   // ---------------- monitor ----------------
   // At negedge all inputs for the next edge are settled: a result presented
   // with ready_in high leaves on that edge, so it is popped; while stalled the
   // held result is compared again each cycle.
   initial begin
      exp_t a;
      forever begin
         @(negedge clk);
         if (valid_s) begin
            a = '{res: res_s, ovf: ovf_s, err: err_s, gt: gt_s, eq: eq_s, lt: lt_s, tag: tag_s};
            if (exp_s_q.size() == 0) begin
               check("sat_unexpected_valid", 64'(valid_s), 64'd0);
            end else begin
               cmp_out("sat", exp_s_q[0], a);
               if (ready_in) void'(exp_s_q.pop_front());
            end
         end
         if (valid_w) begin
            a = '{res: res_w, ovf: ovf_w, err: err_w, gt: gt_w, eq: eq_w, lt: lt_w, tag: tag_w};
            if (exp_w_q.size() == 0) begin
               check("wrap_unexpected_valid", 64'(valid_w), 64'd0);
            end else begin
               cmp_out("wrap", exp_w_q[0], a);
               if (ready_in) void'(exp_w_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [2:0] sel, input logic [W-1:0] d1,
                        input logic [W-1:0] d0, input logic [TW-1:0] tag);
      bit done;
      done     = 1'b0;
      valid_in = 1'b1;
      sel_in   = sel;
      d1_in    = d1;
      d0_in    = d0;
      tag_in   = tag;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (ready_s) begin
            exp_s_q.push_back(model(sel, d1, d0, tag, 1'b1));
            exp_w_q.push_back(model(sel, d1, d0, tag, 1'b0));
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("issue_timeout", 64'd0, 64'd1);
      valid_in = 1'b0;
      sel_in   = 3'($urandom_range(0, 7));
      d1_in    = $urandom;
      d0_in    = $urandom;
   endtask

   task automatic drain();
      ready_in = 1'b1;
      for (int c = 0; c < 200 && (exp_s_q.size() != 0 || exp_w_q.size() != 0); c++) begin
         @(posedge clk);
         #1;
      end
      check("drain_sat_empty", 64'(exp_s_q.size()), 64'd0);
      check("drain_wrap_empty", 64'(exp_w_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'h8000_0000;
         1:       v = 32'h7FFF_FFFF;
         2:       v = 32'($urandom_range(0, 32'h0003_FFFF));
         3:       v = -32'($urandom_range(0, 32'h0003_FFFF));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_valid_s"}, 64'(valid_s), 64'd0);
      check({pfx, "_valid_w"}, 64'(valid_w), 64'd0);
      check({pfx, "_ready_s"}, 64'(ready_s), 64'd1);
      check({pfx, "_res_s"}, 64'(res_s), 64'd0);
      check({pfx, "_tag_s"}, 64'(tag_s), 64'd0);
      check({pfx, "_flags_s"}, 64'({gt_s, eq_s, lt_s, ovf_s, err_s}), 64'd0);
      check({pfx, "_flags_w"}, 64'({gt_w, eq_w, lt_w, ovf_w, err_w}), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   bit rand_done;

   initial begin
      rst_in   = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b1;
      d0_in    = '0;
      d1_in    = '0;
      sel_in   = '0;
      tag_in   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      rst_in = 1'b0;

      // directed vectors, first one with a latency check
      issue(ADD, 32'h0001_8000, 32'h0002_4000, 4'd1);
      check("latency_cycle1_valid", 64'(valid_s), 64'd0);
      @(posedge clk);
      #1;
      check("latency_cycle2_valid", 64'(valid_s), 64'd1);
      check("latency_cycle2_res", 64'(res_s), 64'h0003_C000);
      issue(MUL, 32'h0001_8000, 32'hFFFE_0000, 4'd2);
      issue(SGN, 32'hFFFF_0000, 32'h1234_5678, 4'd3);
      issue(ABS, 32'h8000_0000, 32'h0000_0000, 4'd4);
      issue(ADD, 32'h7FFF_0000, 32'h0002_0000, 4'd5);
      issue(ILL, 32'h0000_0005, 32'h0000_0005, 4'd6);
      issue(MAX, 32'hFFFF_0000, 32'h0002_0000, 4'd7);
      issue(SUB, 32'h8000_0000, 32'h0000_0001, 4'd8);
      issue(MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd9);
      issue(MIN, 32'h8000_0000, 32'h7FFF_FFFF, 4'd10);
      issue(SGN, 32'h0000_0000, 32'h0000_0000, 4'd11);
      issue(MUL, 32'hFFFF_FFFF, 32'h0000_0001, 4'd12);
      drain();

      // backpressure: four back-to-back ops, ready_in low for four cycles
      fork
         begin
            for (int t = 0; t < 4; t++) issue(3'($urandom_range(0, 6)), rand_word(), rand_word(), 4'(t));
         end
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            ready_in = 1'b0;
            @(negedge clk);
            check("stall_ready_out_low", 64'(ready_s), 64'd0);
            check("stall_head_tag", 64'(tag_s), 64'd0);
            repeat (4) @(posedge clk);
            #1;
            check("stall_head_tag_held", 64'(tag_s), 64'd0);
            ready_in = 1'b1;
         end
      join
      drain();

      // reset with two ops in flight
      ready_in = 1'b0;
      issue(ADD, 32'h0001_0000, 32'h0001_0000, 4'd1);
      issue(SUB, 32'h0001_0000, 32'h0003_0000, 4'd2);
      rst_in = 1'b1;
      @(posedge clk);
      #1;
      rst_in = 1'b0;
      exp_s_q.delete();
      exp_w_q.delete();
      check_reset_outputs("after_reset");
      ready_in = 1'b1;
      issue(MUL, 32'h0002_0000, 32'h0003_8000, 4'd9);
      check("post_reset_cycle1_valid", 64'(valid_s), 64'd0);
      @(posedge clk);
      #1;
      check("post_reset_cycle2_valid", 64'(valid_s), 64'd1);
      drain();

      // randomized traffic with random backpressure and input bubbles
      rand_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk);
                  #1;
               end
               issue(3'($urandom_range(0, 7)), rand_word(), rand_word(), 4'($urandom_range(0, 15)));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               ready_in = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
